memory_bank: RTL and testbench
==============================

Name: memory_bank

Overview:
- Byte-addressable data RAM for the RV32 core. Parametrised successor to the 2K slice: configurable depth, registered read path with valid handshake, and optional misaligned-access support.
- Misaligned accesses are either split into a two-cycle access sequence or reported as a fault.
- Sits between the load/store unit and the memory map decoder. Supports word, half-word and byte loads/stores with signed or unsigned extension.

Parameters:
- ADDR_WIDTH, 13, byte-address width; capacity is 2^ADDR_WIDTH bytes, organised as 2^(ADDR_WIDTH-2) words (minimum 3).
- ALLOW_MISALIGNED, 1, 1 = split accesses that cross a word boundary into two cycles; 0 = fault on them.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load; sampled with req.
- width_mode  in  2  00 word, 01 half-word, 10 byte, 11 reserved.
- signed_mode  in  1  1 = sign-extend loaded byte/half, 0 = zero-extend; ignored for word loads and stores.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half-word in [15:0]).
- ready  out  1  bank can accept a request this cycle.
- rvalid  out  1  one-cycle pulse; rdata holds a completed load.
- rdata  out  32  extended load result.
- fault  out  1  one-cycle pulse; request rejected.

Behaviour:
- Reset (reset_n low at a rising edge): ready=1, rvalid=0, fault=0, rdata=0, FSM to IDLE. Memory contents are not cleared and are undefined at power-up.
- Storage is four byte lanes, little-endian: byte address A maps to lane A[1:0] of word A[ADDR_WIDTH-1:2].
- Acceptance: a request is accepted on a rising edge where req=1 and ready=1. req while ready=0 is ignored; the master holds req until accepted.
- FSM states:
  - IDLE: ready=1.
  - SECOND: ready=0; second half of a split access pending.
- Aligned access (word with addr[1:0]=00; half with addr[1:0]!=11; any byte):
  - Store: selected lanes written at the accepting edge; unselected lanes unchanged; no rvalid.
  - Load: rdata updated and rvalid=1 in the cycle after acceptance (latency 1).
  - FSM stays in IDLE, so back-to-back requests are accepted every cycle.
- Misaligned access (word with addr[1:0]!=00; half with addr[1:0]=11), ALLOW_MISALIGNED=1:
  - Accepting edge: access lanes addr[1:0]..3 of word W = addr[ADDR_WIDTH-1:2]. Latch the remaining bytes of wdata, width_mode, signed_mode and W+1. Go to SECOND.
  - Next edge: access lanes 0..n-1 of word W+1, where n is the number of remaining bytes. Return to IDLE.
  - W+1 wraps modulo 2^(ADDR_WIDTH-2); the top word wraps to word 0.
  - Loads assemble both parts little-endian, then extend. rvalid=1 in the cycle after the second edge (latency 2).
- Misaligned access with ALLOW_MISALIGNED=0, or width_mode=11:
  - Accepted (ready stays 1); memory is not modified.
  - fault=1 in the next cycle; rvalid stays 0 and rdata keeps its previous value.
- Extension:
  - Byte: rdata[31:8] = signed_mode ? {24{b[7]}} : 0.
  - Half-word: rdata[31:16] = signed_mode ? {16{h[15]}} : 0.
- rdata holds its value between loads and changes only when rvalid asserts.
- Load and store to the same address in consecutive cycles: the load returns the newly stored data (write-first across edges).
- Reset while in SECOND:
  - The second part is aborted. Bytes already written by the first part stay written.
  - No rvalid or fault is produced for the aborted access.

Test Plan:
- Store word 0x80FF7F01 at 0x10; byte loads: LB 0x11 -> rdata 0x0000007F, LB 0x12 -> 0xFFFFFFFF, LBU 0x12 -> 0x000000FF. Each rvalid pulses exactly 1 cycle after acceptance.
- Same data; half-word loads: LH 0x12 -> 0xFFFF80FF, LHU 0x12 -> 0x000080FF, LH 0x11 -> 0xFFFFFF7F.
- Byte stores: SB 0xAB at 0x13, then LW 0x10 -> 0xABFF7F01; the other lanes are unchanged.
- ALLOW_MISALIGNED=1: zero words 0x20 and 0x24, then SW 0xAABBCCDD at 0x22.
  - ready is 0 for exactly one cycle.
  - LW 0x20 -> 0xCCDD0000, LW 0x24 -> 0x0000AABB.
  - LW 0x22 -> 0xAABBCCDD with rvalid 2 cycles after acceptance.
- Wrap: SH 0x1234 at address 2^ADDR_WIDTH-1 -> LBU top address = 0x34, LBU 0x0 = 0x12. With ALLOW_MISALIGNED=0: LW 0x01 -> fault pulse, rvalid=0, memory unchanged. width_mode=11 -> fault.
- Drive reset_n low during SECOND of SW 0xAABBCCDD at 0x22 (words pre-zeroed):
  - After reset: ready=1, rvalid=0, fault=0.
  - LW 0x20 -> 0xCCDD0000, LW 0x24 -> 0x00000000.

Source files
------------

// File: rtl/memory_bank.sv
// -----------------------------------------------------------------------------
// memory_bank
//   Byte-addressable data RAM for the RV32 load/store unit. Storage is four
//   little-endian byte lanes, so byte address A lives in lane A[1:0] of word
//   A[ADDR_WIDTH-1:2]. Loads return after one cycle (aligned) or two cycles
//   (word-crossing access split into two halves). Misaligned accesses are either
//   split or rejected with a fault pulse, depending on ALLOW_MISALIGNED.
//
// Parameters
//   ADDR_WIDTH        byte-address width (>= 3); capacity 2^ADDR_WIDTH bytes
//   ALLOW_MISALIGNED  1 = split word-crossing accesses, 0 = fault on them
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset_n      synchronous active-low reset
//   req          access request, accepted when ready=1
//   we           1 = store, 0 = load
//   width_mode   00 word, 01 half-word, 10 byte, 11 reserved (faults)
//   signed_mode  1 = sign-extend byte/half loads, 0 = zero-extend
//   addr         byte address
//   wdata        right-aligned store data
//   ready        bank can accept a request this cycle
//   rvalid       one-cycle pulse: rdata holds a completed load
//   rdata        extended load result, held between loads
//   fault        one-cycle pulse: request rejected
// -----------------------------------------------------------------------------
module memory_bank #(
  parameter int ADDR_WIDTH       = 13,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            width_mode,
  input  logic                  signed_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  fault
);

  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int DEPTH  = 1 << WORD_W;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0] off;
  logic [2:0] size;
  logic       misaligned;
  logic       bad;
  logic       accept;
  logic [1:0] first_cnt;   // bytes served by the first word of a split access
  logic [1:0] rest_cnt;    // bytes left for the following word

  always_comb begin
    off = addr[1:0];
    case (width_mode)
      2'b00:   size = 3'd4;
      2'b01:   size = 3'd2;
      default: size = 3'd1;
    endcase
    // An access crosses a word boundary exactly when off + size exceeds 4.
    misaligned = ({1'b0, off} + size) > 3'd4;
    bad        = (width_mode == 2'b11) || (misaligned && !ALLOW_MISALIGNED);
    accept     = req && (state_reg == IDLE);
    first_cnt  = 2'(3'd4 - {1'b0, off});
    rest_cnt   = 2'(({1'b0, off} + size) - 3'd4);
  end

  // ---------------------------------------------------------------------------
  // Pending second half of a split access
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] pend_word_reg;
  logic [31:0]       pend_wdata_reg;
  logic [31:0]       pend_lo_reg;
  logic [1:0]        pend_first_reg;
  logic [1:0]        pend_rest_reg;
  logic              pend_we_reg;
  logic [1:0]        pend_width_reg;
  logic              pend_signed_reg;

  // ---------------------------------------------------------------------------
  // Storage access: address, lane selects and write data for this edge
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] acc_idx;
  logic [3:0]        lane_sel;
  logic [31:0]       lane_wdata;
  logic              do_write;
  logic [31:0]       rd_word;

  always_comb begin
    acc_idx    = addr[ADDR_WIDTH-1:2];
    lane_sel   = '0;
    lane_wdata = wdata << {off, 3'b000};
    do_write   = 1'b0;
    if (state_reg == SECOND) begin
      acc_idx    = pend_word_reg;
      lane_wdata = pend_wdata_reg;
      do_write   = pend_we_reg;
      for (int i = 0; i < 4; i++) begin
        lane_sel[i] = (i < int'(pend_rest_reg));
      end
    end else begin
      do_write = accept && we && !bad;
      // For a split access this selects lanes off..3 only; the tail goes to
      // the next word in SECOND.
      for (int i = 0; i < 4; i++) begin
        lane_sel[i] = (i >= int'(off)) && ((i - int'(off)) < int'(size));
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      // Reset gates the write so an aborted second half never lands.
      always_ff @(posedge clk) begin
        if (reset_n && do_write && lane_sel[gi]) begin
          mem[acc_idx] <= lane_wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem[acc_idx];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && misaligned && !bad) state_next = SECOND;
      SECOND:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign ready = (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (accept && misaligned && !bad) begin
      // Wraps naturally modulo the word count.
      pend_word_reg   <= addr[ADDR_WIDTH-1:2] + WORD_W'(1);
      pend_wdata_reg  <= wdata >> {first_cnt, 3'b000};
      pend_lo_reg     <= rd_word >> {off, 3'b000};
      pend_first_reg  <= first_cnt;
      pend_rest_reg   <= rest_cnt;
      pend_we_reg     <= we;
      pend_width_reg  <= width_mode;
      pend_signed_reg <= signed_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Load result path
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  wm,
                                         input logic        sgn);
    logic [31:0] res;
    case (wm)
      2'b01:   res = {{16{sgn & raw[15]}}, raw[15:0]};
      2'b10:   res = {{24{sgn & raw[7]}},  raw[7:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  logic        rvalid_reg;
  logic        fault_reg;
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid_reg <= 1'b0;
      fault_reg  <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= 1'b0;
      fault_reg  <= 1'b0;
      if (state_reg == SECOND) begin
        if (!pend_we_reg) begin
          // Upper bytes of the second word beyond the access size are
          // discarded by the extension step.
          rdata_reg  <= extend(pend_lo_reg | (rd_word << {pend_first_reg, 3'b000}),
                               pend_width_reg, pend_signed_reg);
          rvalid_reg <= 1'b1;
        end
      end else if (accept) begin
        if (bad) begin
          fault_reg <= 1'b1;
        end else if (!misaligned && !we) begin
          rdata_reg  <= extend(rd_word >> {off, 3'b000}, width_mode, signed_mode);
          rvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign rvalid = rvalid_reg;
  assign fault  = fault_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_memory_bank.sv
// -----------------------------------------------------------------------------
// tb_memory_bank
//   Directed bench for memory_bank. Two instances: dut (misaligned accesses
//   split) and dut_strict (misaligned accesses fault). Shared stimulus, with a
//   per-instance request line chosen by 'sel'.
// -----------------------------------------------------------------------------
module tb_memory_bank;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1;
  logic          we;
  logic [1:0]    width_mode;
  logic          signed_mode;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  logic          ready0, rvalid0, fault0;
  logic          ready1, rvalid1, fault1;
  logic [31:0]   rdata0, rdata1;

  int tests  = 0;
  int failed = 0;

  logic sel = 1'b0;
  logic        ready_s, rvalid_s, fault_s;
  logic [31:0] rdata_s;
  assign ready_s  = sel ? ready1  : ready0;
  assign rvalid_s = sel ? rvalid1 : rvalid0;
  assign fault_s  = sel ? fault1  : fault0;
  assign rdata_s  = sel ? rdata1  : rdata0;

  always #5 clk = ~clk;

  memory_bank #(.ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req0), .we(we),
    .width_mode(width_mode), .signed_mode(signed_mode), .addr(addr),
    .wdata(wdata), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0),
    .fault(fault0)
  );

  memory_bank #(.ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .reset_n(reset_n), .req(req1), .we(we),
    .width_mode(width_mode), .signed_mode(signed_mode), .addr(addr),
    .wdata(wdata), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1),
    .fault(fault1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Present one request and return 1 time unit after the accepting edge.
  task automatic issue(input logic w, input logic [1:0] wm, input logic s,
                       input logic [AW-1:0] a, input logic [31:0] d,
                       input string tag);
    check({tag, " ready"}, 32'(ready_s), 32'd1);
    we = w; width_mode = wm; signed_mode = s; addr = a; wdata = d;
    if (sel) req1 = 1'b1;
    else     req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic store(input logic [1:0] wm, input logic [AW-1:0] a,
                       input logic [31:0] d, input bit split, input string tag);
    issue(1'b1, wm, 1'b0, a, d, tag);
    check({tag, " no rvalid"}, 32'(rvalid_s), 32'd0);
    if (split) begin
      check({tag, " busy"}, 32'(ready_s), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [1:0] wm, input logic s, input logic [AW-1:0] a,
                      input logic [31:0] exp, input int lat, input string tag);
    issue(1'b0, wm, s, a, 32'd0, tag);
    if (lat == 2) begin
      check({tag, " busy"}, 32'(ready_s), 32'd0);
      check({tag, " early rvalid"}, 32'(rvalid_s), 32'd0);
      @(posedge clk); #1;
    end
    check({tag, " rvalid"}, 32'(rvalid_s), 32'd1);
    check(tag, rdata_s, exp);
    @(posedge clk); #1;
    check({tag, " rvalid pulse"}, 32'(rvalid_s), 32'd0);
  endtask

  task automatic expect_fault(input logic w, input logic [1:0] wm,
                              input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [31:0] prev_rdata, input string tag);
    issue(w, wm, 1'b0, a, d, tag);
    check({tag, " fault"}, 32'(fault_s), 32'd1);
    check({tag, " no rvalid"}, 32'(rvalid_s), 32'd0);
    check({tag, " still ready"}, 32'(ready_s), 32'd1);
    check({tag, " rdata kept"}, rdata_s, prev_rdata);
    @(posedge clk); #1;
    check({tag, " fault pulse"}, 32'(fault_s), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0;
    width_mode = 2'b00; signed_mode = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    check("reset ready",  32'(ready0),  32'd1);
    check("reset rvalid", 32'(rvalid0), 32'd0);
    check("reset fault",  32'(fault0),  32'd0);
    check("reset rdata",  rdata0,       32'd0);
    reset_n = 1'b1;

    // Byte and half-word extension
    store(2'b00, 13'h010, 32'h80FF7F01, 1'b0, "SW 0x10");
    load(2'b10, 1'b1, 13'h011, 32'h0000007F, 1, "LB 0x11");
    load(2'b10, 1'b1, 13'h012, 32'hFFFFFFFF, 1, "LB 0x12");
    load(2'b10, 1'b0, 13'h012, 32'h000000FF, 1, "LBU 0x12");
    load(2'b01, 1'b1, 13'h012, 32'hFFFF80FF, 1, "LH 0x12");
    load(2'b01, 1'b0, 13'h012, 32'h000080FF, 1, "LHU 0x12");
    load(2'b01, 1'b1, 13'h011, 32'hFFFFFF7F, 1, "LH 0x11");
    load(2'b00, 1'b0, 13'h010, 32'h80FF7F01, 1, "LW 0x10");

    // Byte store, immediately read back (write-first across edges)
    store(2'b10, 13'h013, 32'h000000AB, 1'b0, "SB 0x13");
    load(2'b00, 1'b0, 13'h010, 32'hABFF7F01, 1, "LW 0x10 after SB");

    // Split word store and loads
    store(2'b00, 13'h020, 32'h00000000, 1'b0, "SW 0x20 zero");
    store(2'b00, 13'h024, 32'h00000000, 1'b0, "SW 0x24 zero");
    store(2'b00, 13'h022, 32'hAABBCCDD, 1'b1, "SW 0x22 split");
    load(2'b00, 1'b0, 13'h020, 32'hCCDD0000, 1, "LW 0x20");
    load(2'b00, 1'b0, 13'h024, 32'h0000AABB, 1, "LW 0x24");
    load(2'b00, 1'b0, 13'h022, 32'hAABBCCDD, 2, "LW 0x22 split");
    load(2'b01, 1'b1, 13'h023, 32'hFFFFBBCC, 2, "LH 0x23 split");

    // Split half-word wrapping from the top address to address 0
    store(2'b01, 13'h1FFF, 32'h00001234, 1'b1, "SH top wrap");
    load(2'b10, 1'b0, 13'h1FFF, 32'h00000034, 1, "LBU top");
    load(2'b01, 1'b0, 13'h1FFF, 32'h00001234, 2, "LHU top wrap");
    load(2'b10, 1'b0, 13'h0000, 32'h00000012, 1, "LBU 0x0");

    // Reserved width faults
    expect_fault(1'b0, 2'b11, 13'h010, 32'd0, 32'h00000012, "LD width11");

    // Strict instance: misaligned faults, memory untouched
    sel = 1'b1;
    store(2'b00, 13'h000, 32'h11223344, 1'b0, "strict SW 0x0");
    load(2'b00, 1'b0, 13'h000, 32'h11223344, 1, "strict LW 0x0");
    expect_fault(1'b0, 2'b00, 13'h001, 32'd0, 32'h11223344, "strict LW 0x1");
    expect_fault(1'b1, 2'b00, 13'h001, 32'hDEADBEEF, 32'h11223344, "strict SW 0x1");
    load(2'b00, 1'b0, 13'h000, 32'h11223344, 1, "strict LW 0x0 again");

    // Reset during the second half of a split store
    sel = 1'b0;
    store(2'b00, 13'h020, 32'h00000000, 1'b0, "SW 0x20 zero2");
    store(2'b00, 13'h024, 32'h00000000, 1'b0, "SW 0x24 zero2");
    issue(1'b1, 2'b00, 1'b0, 13'h022, 32'hAABBCCDD, "SW 0x22 abort");
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort ready",  32'(ready0),  32'd1);
    check("abort rvalid", 32'(rvalid0), 32'd0);
    check("abort fault",  32'(fault0),  32'd0);
    reset_n = 1'b1;
    load(2'b00, 1'b0, 13'h020, 32'hCCDD0000, 1, "LW 0x20 after abort");
    load(2'b00, 1'b0, 13'h024, 32'h00000000, 1, "LW 0x24 after abort");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
